// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the RAM arbiter slice.
// Contents: FSM state encoding and a wrap-around index increment helper.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StClear  = 2'd2
  } state_e;

  // Next index after idx in a ring of n entries.
  function automatic int unsigned rr_wrap_inc(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the requesters / RAM and the RAM arbiter.
// slave  : arbiter side (consumes requests and mem_rdata, drives acks and RAM pins)
// master : environment side (requesters plus the RAM model returning mem_rdata)
interface ram_arbiter_if #(
  parameter int unsigned BitWidth = 16,
  parameter int unsigned SelWidth = 3,
  parameter int unsigned NumReq   = 2
) ();

  logic [NumReq-1:0]          req;
  logic [NumReq-1:0]          we;
  logic [NumReq*SelWidth-1:0] addr;
  logic [NumReq*BitWidth-1:0] wdata;
  logic [NumReq-1:0]          ack;
  logic [BitWidth-1:0]        rdata;
  logic                       clear;
  logic                       busy;
  logic [SelWidth-1:0]        mem_address;
  logic [BitWidth-1:0]        mem_in;
  logic                       mem_load;
  logic                       mem_reset;
  logic [BitWidth-1:0]        mem_rdata;

  modport slave (
    input  req, we, addr, wdata, clear, mem_rdata,
    output ack, rdata, busy, mem_address, mem_in, mem_load, mem_reset
  );

  modport master (
    output req, we, addr, wdata, clear, mem_rdata,
    input  ack, rdata, busy, mem_address, mem_in, mem_load, mem_reset
  );

endinterface

// File: rtl/ram_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// req_i : request vector
// ptr_i : index holding highest priority this round
// idx_o : winner, the first set request at or after ptr_i (wrapping)
// any_o : at least one request is set
module rr_arbiter #(
  parameter int unsigned NumReq = 2,
  parameter int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic [IdxW-1:0]   idx_o,
  output logic              any_o
);

  int unsigned cand;

  // Scan from the farthest offset back to ptr_i so the closest request wins.
  always_comb begin
    idx_o = '0;
    any_o = |req_i;
    cand  = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      cand = (32'(ptr_i) + NumReq - 1 - k) % NumReq;
      if (req_i[cand[IdxW-1:0]]) begin
        idx_o = cand[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one register RAM between NumReq requesters: round-robin grant, one read or
// write per transaction (latched at grant, executed in a single ACCESS cycle), plus a
// clear sweep that writes zero to every word.
// clock_i : system clock
// reset_i : synchronous active-high reset, also passed to the RAM reset pin
// arb_io  : requester handshake, clear/busy and RAM pins
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned BitWidth = 16,
  parameter int unsigned SelWidth = 3,
  parameter int unsigned NumReq   = 2
) (
  input  logic          clock_i,
  input  logic          reset_i,
  ram_arbiter_if.slave  arb_io
);

  localparam int unsigned IdxW = $clog2(NumReq);

  state_e               state_q, state_d;
  logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]      gnt_q, gnt_d;
  logic                 we_q, we_d;
  logic [SelWidth-1:0]  addr_q, addr_d;
  logic [BitWidth-1:0]  wdata_q, wdata_d;
  logic [SelWidth-1:0]  clr_cnt_q, clr_cnt_d;

  logic [IdxW-1:0]      win_idx;
  logic                 win_any;

  logic [NumReq-1:0]    ack;
  logic [BitWidth-1:0]  rdata;
  logic                 busy;
  logic [SelWidth-1:0]  mem_address;
  logic [BitWidth-1:0]  mem_in;
  logic                 mem_load;

  rr_arbiter #(
    .NumReq (NumReq)
  ) u_rr_arbiter (
    .req_i (arb_io.req),
    .ptr_i (rr_ptr_q),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    clr_cnt_d   = clr_cnt_q;
    ack         = '0;
    rdata       = '0;
    busy        = 1'b0;
    mem_address = '0;
    mem_in      = '0;
    mem_load    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Clear takes priority over any pending request.
        if (arb_io.clear) begin
          state_d   = StClear;
          clr_cnt_d = '0;
        end else if (win_any) begin
          state_d = StAccess;
          gnt_d   = win_idx;
          we_d    = arb_io.we[win_idx];
          addr_d  = arb_io.addr[win_idx*SelWidth +: SelWidth];
          wdata_d = arb_io.wdata[win_idx*BitWidth +: BitWidth];
        end
      end
      StAccess: begin
        mem_address = addr_q;
        mem_in      = wdata_q;
        mem_load    = we_q;
        ack[gnt_q]  = 1'b1;
        rdata       = arb_io.mem_rdata;
        rr_ptr_d    = IdxW'(rr_wrap_inc(32'(gnt_q), NumReq));
        state_d     = StIdle;
      end
      StClear: begin
        mem_address = clr_cnt_q;
        mem_load    = 1'b1;
        busy        = 1'b1;
        clr_cnt_d   = clr_cnt_q + SelWidth'(1);
        if (clr_cnt_q == {SelWidth{1'b1}}) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // While reset is asserted the RAM reloads from mem_in, so keep it zero and
    // suppress any ack from an aborted transaction.
    if (reset_i) begin
      ack         = '0;
      rdata       = '0;
      busy        = 1'b0;
      mem_address = '0;
      mem_in      = '0;
      mem_load    = 1'b0;
    end
  end

  assign arb_io.ack         = ack;
  assign arb_io.rdata       = rdata;
  assign arb_io.busy        = busy;
  assign arb_io.mem_address = mem_address;
  assign arb_io.mem_in      = mem_in;
  assign arb_io.mem_load    = mem_load;
  assign arb_io.mem_reset   = reset_i;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Sequencing front-end that shares one p_ram-style register RAM (ram8/ram64/...) between NUM_REQ requesters, e.g. CPU fetch and data ports.
- Arbitrates round-robin and performs one read or write per granted transaction.
- Also runs a hardware clear sweep that writes zero to every word.
- Sits between the requesters and the RAM's in/address/load/reset pins; a read word is supplied back through mem_rdata.

Parameters:
- BIT_WIDTH, 16, data word width; must match the RAM instance.
- SEL_WIDTH, 3, address width; the RAM depth is 2**SEL_WIDTH.
- NUM_REQ, 2, number of requesters (at least 2).

Ports:
- clock  input  1  single system clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- req  input  NUM_REQ  per-requester transaction request; held until ack
- we  input  NUM_REQ  per-requester write enable (1 = write, 0 = read); held with req
- addr  input  NUM_REQ*SEL_WIDTH  packed addresses; requester i uses bits [i*SEL_WIDTH +: SEL_WIDTH]
- wdata  input  NUM_REQ*BIT_WIDTH  packed write data; requester i uses bits [i*BIT_WIDTH +: BIT_WIDTH]
- ack  output  NUM_REQ  one-hot completion strobe
- rdata  output  BIT_WIDTH  read data; valid only while the acked transaction is a read
- clear  input  1  request to zero the whole RAM
- busy  output  1  high while a clear sweep is in progress
- mem_address  output  SEL_WIDTH  drives the RAM address pin
- mem_in  output  BIT_WIDTH  drives the RAM in pin
- mem_load  output  1  drives the RAM load pin
- mem_reset  output  1  drives the RAM reset pin
- mem_rdata  input  BIT_WIDTH  RAM word currently at mem_address (combinational)

Behaviour:
- States: IDLE, ACCESS, CLEAR.
  - Reset forces IDLE and rr_ptr = 0.
  - Reset also forces ack = 0, busy = 0, mem_load = 0, mem_address = 0 and mem_in = 0.
  - mem_reset = reset, passed straight through. The RAM loads mem_in into every cell on reset, so the RAM comes out of reset all-zero.
- IDLE, evaluated at each rising edge (in priority order):
  - clear = 1: go to CLEAR with clr_cnt = 0. Clear beats pending requests.
  - else, any req = 1: the round-robin winner is the first set req at or after rr_ptr, wrapping at NUM_REQ.
    - Latch gnt_idx and that requester's we, addr and wdata.
    - Go to ACCESS.
  - In IDLE: mem_load = 0, ack = 0.
- ACCESS, always exactly 1 cycle:
  - mem_address = latched addr, mem_in = latched wdata, mem_load = latched we.
  - ack[gnt_idx] = 1 combinationally in this cycle.
  - rdata = mem_rdata, combinational, in this cycle.
  - The write commits at the closing edge.
  - At that edge: rr_ptr = (gnt_idx + 1) mod NUM_REQ; next state is IDLE.
- Handshake rules:
  - A requester holds req/we/addr/wdata stable until it samples ack = 1.
  - It must drop req (or present a new transaction) at that same edge.
  - Latency is 1 cycle from the req-sampling edge to the ack cycle.
  - Peak throughput is one transaction per 2 cycles.
  - Requester inputs may change during ACCESS without effect, because the transaction was latched.
- CLEAR:
  - Drives mem_address = clr_cnt, mem_in = 0, mem_load = 1; busy = 1.
  - clr_cnt increments every cycle.
  - In the cycle clr_cnt = 2**SEL_WIDTH-1, go to IDLE. The sweep lasts exactly 2**SEL_WIDTH cycles.
  - No acks are issued during CLEAR; pending reqs wait.
  - clear asserted during CLEAR is ignored, with no restart.
  - clear held high through the final cycle starts a new sweep on the following IDLE evaluation.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NUM_REQ-1,0,...
- Simultaneous events:
  - clear and req in the same IDLE cycle: clear wins, and the req is served after the sweep.
  - Two reqs: rr_ptr decides the winner.
- Reset mid-ACCESS or mid-CLEAR:
  - Abort and return to IDLE next cycle; no ack is issued.
  - The RAM is zeroed via mem_reset with mem_in = 0.
- Widths: clr_cnt is SEL_WIDTH+1 bits or a terminal-count compare, with no silent overflow. gnt_idx is $clog2(NUM_REQ) bits.

Decomposition:
- Shared header: state encodings IDLE = 2'd0, ACCESS = 2'd1, CLEAR = 2'd2.
- One sub-module, rr_arbiter:
  - Combinational inputs: req and ptr.
  - Outputs: the winner index and an any-request flag.
  - Reusable for future bus arbitration.

Test Plan:
1. Reset, then req[0] = 1, we = 1, addr = 3, wdata = 16'hBEEF → ack[0] one cycle later with mem_load = 1 and mem_address = 3. A following read of addr 3 returns rdata = 16'hBEEF with ack[0].
2. req = 2'b11 held continuously, both reads → ack sequence 0,1,0,1, with one ack every 2 cycles.
3. Write 16'h1234 to every address, then pulse clear → busy high for exactly 8 cycles with mem_address 0..7 and mem_in = 0. Afterwards every read returns 0.
4. clear and req[1] asserted in the same cycle → CLEAR runs first. ack[1] arrives in the cycle after busy falls plus 1.
5. Assert reset during the 4th clear cycle → busy = 0 next cycle, no ack, all words read 0, rr_ptr = 0 (req = 2'b11 grants requester 0 first).
6. req[1] write addr 7 = 16'h00FF with requester inputs changed during ACCESS → the RAM word at 7 holds 16'h00FF; the changed values are ignored.
